// File: rtl/kalman_pkg.sv
// Shared widths, default noise constants, FSM encoding and saturation helpers
// for the scalar Kalman filter on the fast-ADC channel A stream.
package kalman_pkg;

    // Datapath widths: ADC sample, output estimate, fraction bits, state word
    localparam int ADC_W = 14;
    localparam int OUT_W = 16;
    localparam int FRAC  = 16;
    localparam int ST_W  = 32;

    // Default filter tuning, all unsigned Q16.16
    localparam logic [ST_W-1:0] Q_NOISE_DEF = 32'h0000_0100;  // 1/256
    localparam logic [ST_W-1:0] R_NOISE_DEF = 32'h0010_0000;  // 16.0
    localparam logic [ST_W-1:0] P_INIT_DEF  = 32'h0001_0000;  // 1.0

    // Update sequencer: wait for a sample, run the gain divider, apply update
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        UPD  = 2'd2
    } kf_state_t;

    // Clamp a 17-bit signed value into the 16-bit signed range
    function automatic logic [OUT_W-1:0] sat16(input logic signed [OUT_W:0] v);
        if (v > 17'sd32767) begin
            return 16'h7FFF;
        end else if (v < -17'sd32768) begin
            return 16'h8000;
        end else begin
            return v[OUT_W-1:0];
        end
    endfunction

    // Clamp a 16-bit signed value into the 14-bit DAC range [-8192, 8191]
    function automatic logic [ADC_W-1:0] sat14(input logic signed [OUT_W-1:0] v);
        if (v > 16'sd8191) begin
            return 14'h1FFF;
        end else if (v < -16'sd8192) begin
            return 14'h2000;
        end else begin
            return v[ADC_W-1:0];
        end
    endfunction

endpackage

// File: rtl/kalman_div.sv
// Sequential restoring divider producing a 16-bit fractional quotient
// floor(num * 2^16 / den) for num < den, one quotient bit per clock.
//
// Handshake: i_start is accepted only while the divider is idle and loads
// the operands on that edge. The next 16 edges each resolve one quotient bit.
// o_done is high during the cycle whose closing edge writes the last bit, so
// o_quo holds the complete quotient from the cycle after o_done onwards and
// stays stable until the next accepted start.
module kalman_div
    import kalman_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ST_W:0]     i_num,
    input  logic [ST_W:0]     i_den,
    output logic              o_done,
    output logic [FRAC-1:0]   o_quo
);

    // Partial remainder needs one spare bit because it is doubled before compare
    logic [ST_W+1:0] r_rem;
    logic [ST_W:0]   r_den;
    logic [FRAC-1:0] r_quo;
    logic [3:0]      r_cnt;
    logic            r_busy;

    logic [ST_W+1:0] w_shift;
    logic [ST_W+1:0] w_sub;
    logic            w_ge;
    logic [ST_W+1:0] w_rem_next;

    // One restoring step: double the remainder, subtract divisor if it fits
    always_comb begin
        w_shift    = r_rem << 1;
        w_ge       = (w_shift >= {1'b0, r_den});
        w_sub      = w_shift - {1'b0, r_den};
        w_rem_next = w_ge ? w_sub : w_shift;
    end

    // Operand load on start, then 16 iterations shifting quotient bits in
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rem  <= '0;
            r_den  <= '0;
            r_quo  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start && !r_busy) begin
            r_rem  <= {1'b0, i_num};
            r_den  <= i_den;
            r_quo  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_rem <= w_rem_next;
            r_quo <= {r_quo[FRAC-2:0], w_ge};
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt == 4'd15) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign o_done = r_busy && (r_cnt == 4'd15);
    assign o_quo  = r_quo;

endmodule

// File: rtl/kalman_filter_system.sv
// Scalar constant-state Kalman filter on the ADC channel A sample stream.
// A valid sample (adc_dat_b_i[0]) seen while idle is captured, the gain
// K = Pp / (Pp + R) is computed by a 16-cycle divider, and the estimate and
// covariance are updated one cycle later. Samples arriving mid-update are
// dropped. The rounded estimate drives x_dat, the DAC and the LEDs.
module kalman_filter_system
    import kalman_pkg::*;
#(
    parameter logic [ST_W-1:0] Q_NOISE = Q_NOISE_DEF,
    parameter logic [ST_W-1:0] R_NOISE = R_NOISE_DEF,
    parameter logic [ST_W-1:0] P_INIT  = P_INIT_DEF
)
(
    input  logic              adc_clk_i,
    input  logic              adc_rst_i,
    input  logic [ADC_W-1:0]  adc_dat_a_i,
    input  logic [ADC_W-1:0]  adc_dat_b_i,
    output logic [OUT_W-1:0]  x_dat,
    output logic              x_vld_o,
    output logic              busy_o,
    output logic [ADC_W-1:0]  dac_dat_o,
    output logic [7:0]        led_o
);

    // Filter state and update bookkeeping
    kf_state_t               r_state;
    kf_state_t               w_state_next;
    logic signed [ST_W-1:0]  r_x;        // estimate, signed Q16.16
    logic [ST_W-1:0]         r_p;        // error covariance, unsigned Q16.16
    logic [ST_W-1:0]         r_pp;       // predicted covariance for this update
    logic [ADC_W-1:0]        r_z;        // captured measurement
    logic [OUT_W-1:0]        r_x_dat;
    logic                    r_x_vld;
    logic                    r_busy;

    logic                    w_valid;
    logic                    w_capture;
    logic                    w_update;
    logic                    w_unused;

    // Prediction: Pp = sat32(P + Q), and the divider denominator Pp + R
    logic [ST_W:0]           w_pp_sum;
    logic [ST_W-1:0]         w_pp_sat;
    logic [ST_W:0]           w_den;

    // Divider result (gain K, unsigned Q0.16, always below 1.0)
    logic                    w_div_done;
    logic [FRAC-1:0]         w_quo;

    // Update arithmetic
    logic signed [ST_W+1:0]  w_z_q;      // z * 2^16, 34-bit signed
    logic signed [ST_W+1:0]  w_x_ext;
    logic signed [ST_W+1:0]  w_e;        // innovation z*2^16 - x
    logic signed [50:0]      w_k51;
    logic signed [50:0]      w_e51;
    logic signed [50:0]      w_ke;
    logic signed [ST_W-1:0]  w_dx;
    logic signed [ST_W-1:0]  w_x_new;
    logic signed [ST_W:0]    w_x_rnd;
    logic signed [OUT_W:0]   w_x_int;
    logic [FRAC:0]           w_omk;      // 1.0 - K
    logic [48:0]             w_pk;
    logic [ST_W-1:0]         w_p_new;

    assign w_valid   = adc_dat_b_i[0];
    // Upper channel B bits carry no meaning for this block
    assign w_unused  = ^adc_dat_b_i[ADC_W-1:1];
    assign w_capture = (r_state == IDLE) && w_valid;
    assign w_update  = (r_state == UPD);

    assign w_pp_sum = {1'b0, r_p} + {1'b0, Q_NOISE};
    assign w_pp_sat = w_pp_sum[ST_W] ? {ST_W{1'b1}} : w_pp_sum[ST_W-1:0];
    assign w_den    = {1'b0, w_pp_sat} + {1'b0, R_NOISE};

    // Gain divider is loaded on the capture edge straight from the prediction
    kalman_div u_div (
        .i_clk   (adc_clk_i),
        .i_rst   (adc_rst_i),
        .i_start (w_capture),
        .i_num   ({1'b0, w_pp_sat}),
        .i_den   (w_den),
        .o_done  (w_div_done),
        .o_quo   (w_quo)
    );

    // Estimate and covariance update from the captured sample and gain
    always_comb begin
        w_z_q   = {{4{r_z[ADC_W-1]}}, r_z, {FRAC{1'b0}}};
        w_x_ext = {{2{r_x[ST_W-1]}}, r_x};
        w_e     = w_z_q - w_x_ext;
        w_k51   = {35'd0, w_quo};
        w_e51   = {{17{w_e[ST_W+1]}}, w_e};
        w_ke    = w_k51 * w_e51;
        w_dx    = 32'(w_ke >>> FRAC);
        w_x_new = r_x + w_dx;
        w_x_rnd = {w_x_new[ST_W-1], w_x_new} + 33'sd32768;
        w_x_int = 17'(w_x_rnd >>> FRAC);
        w_omk   = 17'h10000 - {1'b0, w_quo};
        w_pk    = {32'd0, w_omk} * {17'd0, r_pp};
        w_p_new = 32'(w_pk >> FRAC);
    end

    // FSM state register
    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state: IDLE -> DIV on a valid sample, DIV -> UPD on the final
    // divider step, UPD -> IDLE after one cycle
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_valid)    w_state_next = DIV;
            DIV:     if (w_div_done) w_state_next = UPD;
            UPD:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Sample capture, state update and registered outputs
    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            r_x     <= '0;
            r_p     <= P_INIT;
            r_pp    <= '0;
            r_z     <= '0;
            r_x_dat <= '0;
            r_x_vld <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_x_vld <= 1'b0;
            if (w_capture) begin
                r_z    <= adc_dat_a_i;
                r_pp   <= w_pp_sat;
                r_busy <= 1'b1;
            end
            if (w_update) begin
                r_x     <= w_x_new;
                r_p     <= w_p_new;
                r_x_dat <= sat16(w_x_int);
                r_x_vld <= 1'b1;
                r_busy  <= 1'b0;
            end
        end
    end

    assign x_dat     = r_x_dat;
    assign x_vld_o   = r_x_vld;
    assign busy_o    = r_busy;
    assign dac_dat_o = sat14($signed(r_x_dat));
    assign led_o     = r_x_dat[13:6];

endmodule

// File: tb/tb_kalman_filter_system.sv
// Bench for kalman_filter_system: a floating-free integer reference of the
// scalar Kalman recursion predicts every update value and its timing.
module tb_kalman_filter_system;

  localparam longint Q_N  = 64'h100;
  localparam longint R_N  = 64'h0010_0000;
  localparam longint P0   = 64'h0001_0000;
  localparam longint PMAX = 64'h0000_0000_FFFF_FFFF;

  // ---------------- clock / reset / DUT ----------------
  logic        adc_clk_i = 1'b0;
  logic        adc_rst_i;
  logic [13:0] adc_dat_a_i;
  logic [13:0] adc_dat_b_i;
  logic [15:0] x_dat;
  logic        x_vld_o;
  logic        busy_o;
  logic [13:0] dac_dat_o;
  logic [7:0]  led_o;

  always #4 adc_clk_i = ~adc_clk_i;

  kalman_filter_system dut (
    .adc_clk_i   (adc_clk_i),
    .adc_rst_i   (adc_rst_i),
    .adc_dat_a_i (adc_dat_a_i),
    .adc_dat_b_i (adc_dat_b_i),
    .x_dat       (x_dat),
    .x_vld_o     (x_vld_o),
    .busy_o      (busy_o),
    .dac_dat_o   (dac_dat_o),
    .led_o       (led_o)
  );

  // ---------------- scoreboard state ----------------
  int total;
  int bad;
  int cyc;
  int cap_cyc;
  bit cap_active;
  longint m_x;
  longint m_p;
  logic [15:0] exp_q[$];
  int due_q[$];
  logic [15:0] last_xd;
  bit mono_on;
  logic signed [15:0] mono_prev;

  typedef struct {
    logic [13:0] z;
    logic [15:0] x;
    logic [13:0] dac;
    logic [7:0]  led;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: one Kalman step from the recursion, plain 64-bit arithmetic
  function automatic logic [15:0] model_update(input int zi);
    longint pp;
    longint k;
    longint e;
    longint xd;
    pp = m_p + Q_N;
    if (pp > PMAX) pp = PMAX;
    k = (pp * 65536) / (pp + R_N);
    e = longint'(zi) * 65536 - m_x;
    m_x = m_x + ((k * e) >>> 16);
    m_p = ((65536 - k) * pp) >>> 16;
    xd = (m_x + 32768) >>> 16;
    if (xd > 32767) xd = 32767;
    if (xd < -32768) xd = -32768;
    return xd[15:0];
  endfunction

  function automatic logic [13:0] exp_dac(input logic [15:0] xd);
    int v;
    v = int'($signed(xd));
    if (v > 8191) v = 8191;
    if (v < -8192) v = -8192;
    return v[13:0];
  endfunction

  task automatic check_cycle();
    bit exp_busy;
    exp_busy = cap_active && ((cyc - cap_cyc) <= 16);
    check("busy_o", busy_o, exp_busy);
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      check("x_vld_o pulse", x_vld_o, 1);
      last_xd = exp_q.pop_front();
      void'(due_q.pop_front());
      if (mono_on) begin
        check("x_dat monotonic", longint'($signed(x_dat) >= mono_prev), 1);
        mono_prev = $signed(x_dat);
      end
    end else begin
      check("x_vld_o quiet", x_vld_o, 0);
    end
    check("x_dat", x_dat, last_xd);
    check("dac_dat_o", dac_dat_o, exp_dac(last_xd));
    check("led_o", led_o, last_xd[13:6]);
  endtask

  // ---------------- driver ----------------
  task automatic tick(input bit v, input logic [13:0] z);
    adc_dat_a_i = z;
    adc_dat_b_i = {13'($urandom), v};
    @(posedge adc_clk_i);
    cyc++;
    if (adc_rst_i) begin
      m_x = 0;
      m_p = P0;
      cap_active = 0;
      exp_q.delete();
      due_q.delete();
      last_xd = '0;
    end else if (v && (!cap_active || (cyc - cap_cyc) >= 18)) begin
      cap_active = 1;
      cap_cyc = cyc;
      exp_q.push_back(model_update(int'($signed(z))));
      due_q.push_back(cyc + 17);
    end
    #1;
    check_cycle();
  endtask

  task automatic do_reset(input int n);
    adc_rst_i = 1'b1;
    repeat (n) tick(0, 14'($urandom));
    adc_rst_i = 1'b0;
  endtask

  task automatic drain();
    repeat (20) tick(0, 14'h0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    total = 0;
    bad = 0;
    cyc = 0;
    cap_cyc = 0;
    cap_active = 0;
    m_x = 0;
    m_p = P0;
    last_xd = '0;
    mono_on = 0;
    mono_prev = '0;
    adc_rst_i = 1'b1;
    adc_dat_a_i = '0;
    adc_dat_b_i = '0;

    vecs[0] = '{14'h0123, 16'h0011, 14'h0011, 8'h00};
    vecs[1] = '{14'h1FFF, 16'h01E4, 14'h01E4, 8'h07};
    vecs[2] = '{14'h2000, 16'hFE1C, 14'h3E1C, 8'hF8};
    vecs[3] = '{14'h3FFF, 16'h0000, 14'h0000, 8'h00};
    vecs[4] = '{14'h0011, 16'h0001, 14'h0001, 8'h00};
    vecs[5] = '{14'h0009, 16'h0001, 14'h0001, 8'h00};
    vecs[6] = '{14'h0008, 16'h0000, 14'h0000, 8'h00};
    vecs[7] = '{14'h3FF7, 16'hFFFF, 14'h3FFF, 8'hFF};

    // Reset hold, then idle with valid low
    do_reset(5);
    check("reset x_dat", x_dat, 0);
    check("reset busy_o", busy_o, 0);
    check("reset dac_dat_o", dac_dat_o, 0);
    check("reset led_o", led_o, 0);
    repeat (100) tick(0, 14'($urandom));
    check("idle x_dat", x_dat, 0);

    // First update from reset state
    tick(1, 14'h123);
    repeat (16) tick(0, 14'h0);
    check("first vld early", x_vld_o, 0);
    tick(0, 14'h0);
    check("first vld at 17", x_vld_o, 1);
    check("first x_dat", x_dat, 16'h0011);
    check("first dac", dac_dat_o, 14'h0011);

    // Single-sample table from reset: rounding boundaries and extremes
    for (int i = 0; i < 8; i++) begin
      do_reset(1);
      tick(1, vecs[i].z);
      repeat (17) tick(0, 14'h0);
      check("table x_dat", x_dat, vecs[i].x);
      check("table dac", dac_dat_o, vecs[i].dac);
      check("table led", led_o, vecs[i].led);
    end

    // Continuous 0x123 until settled
    do_reset(1);
    repeat (1000 * 18) tick(1, 14'h123);
    drain();
    check("settle 0123", x_dat, 16'h0123);

    // Valid low with a different value: nothing moves
    repeat (1000) tick(0, 14'h423);
    check("hold 0123", x_dat, 16'h0123);

    // Step up to 0x223, monotonic rise
    mono_on = 1;
    mono_prev = 16'sh0123;
    repeat (1000 * 18) tick(1, 14'h223);
    mono_on = 0;
    drain();
    check("settle 0223", x_dat, 16'h0223);

    // Most negative input
    repeat (1000 * 18) tick(1, 14'h2000);
    drain();
    check("settle E000", x_dat, 16'hE000);
    check("settle dac 2000", dac_dat_o, 14'h2000);

    // Reset in the middle of the divide phase
    tick(1, 14'h123);
    repeat (5) tick(0, 14'h0);
    adc_rst_i = 1'b1;
    tick(1, 14'h123);
    adc_rst_i = 1'b0;
    check("abort x_dat", x_dat, 0);
    check("abort vld", x_vld_o, 0);
    check("abort busy", busy_o, 0);
    check("abort dac", dac_dat_o, 0);
    check("abort led", led_o, 0);
    tick(1, 14'h123);
    repeat (17) tick(0, 14'h0);
    check("after abort x_dat", x_dat, 16'h0011);

    // Random samples, random valid, rare resets
    do_reset(1);
    for (int i = 0; i < 3000; i++) begin
      adc_rst_i = ($urandom_range(0, 499) == 0);
      tick($urandom_range(0, 2) != 0, 14'($urandom));
    end
    adc_rst_i = 1'b0;
    drain();
    check("random queue drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
